bin2bcd: RTL and testbench

BIN2BCD -- requirements
Module: bin2bcd

---
 rtl/bin2bcd_pkg.sv | 20 ++
 rtl/bcd_adj3.sv | 19 +
 rtl/bin2bcd.sv | 114 +++++++++++
 tb/tb_bin2bcd.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bin2bcd_pkg;

  // Converter control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  // One packed BCD digit.
  typedef logic [3:0] bcd_digit_t;

  // Four digits cover every legal operand (up to 8191).
  localparam int NUM_DIGITS = 4;

  // Digits strictly above this get +3 before each shift (double-dabble).
  localparam bcd_digit_t ADJ_THRESH = 4'd4;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: add 3 to a digit above 4 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_adj3
  import bin2bcd_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t q
);

  // Conditional +3; the input never exceeds 9, so the result fits in 4 bits.
  always_comb begin
    if (d > ADJ_THRESH) begin
      q = d + 4'd3;
    end else begin
      q = d;
    end
  end

endmodule

// File: rtl/bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// A conversion of BIN_W bits takes BIN_W OP cycles plus one DONE cycle.
module bin2bcd
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             ready,
  output logic             done_tick,
  output logic [3:0]       bcd3,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd0
);

  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam int DIG_BITS = 4 * NUM_DIGITS;

  state_t                          state_r, state_s;
  logic [BIN_W-1:0]                shift_r, shift_s;
  logic [CNT_W-1:0]                cnt_r, cnt_s;
  bcd_digit_t [NUM_DIGITS-1:0]     digits_r, digits_s;
  bcd_digit_t [NUM_DIGITS-1:0]     adj_s;
  logic [DIG_BITS-1:0]             adj_flat_s;

  // One correction unit per digit, fed from the registered digits.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .d (digits_r[g]),
      .q (adj_s[g])
    );
  end

  assign adj_flat_s = adj_s;

  // Next-state and datapath update: load on start, shift in OP, hold otherwise.
  always_comb begin
    state_s  = state_r;
    shift_s  = shift_r;
    cnt_s    = cnt_r;
    digits_s = digits_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          shift_s  = bin;
          digits_s = {DIG_BITS{1'b0}};
          cnt_s    = CNT_W'(BIN_W);
          state_s  = OP;
        end else begin
          state_s  = IDLE;
        end
      end
      OP: begin
        // Corrected digits and the operand shift left as one long register;
        // the operand MSB enters the units digit.
        digits_s = {adj_flat_s[DIG_BITS-2:0], shift_r[BIN_W-1]};
        shift_s  = {shift_r[BIN_W-2:0], 1'b0};
        if (cnt_r != {CNT_W{1'b0}}) begin
          cnt_s = cnt_r - CNT_W'(1);
        end else begin
          cnt_s = cnt_r;
        end
        if (cnt_r <= CNT_W'(1)) begin
          state_s = DONE;
        end else begin
          state_s = OP;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      shift_r  <= {BIN_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      digits_r <= {DIG_BITS{1'b0}};
    end else begin
      state_r  <= state_s;
      shift_r  <= shift_s;
      cnt_r    <= cnt_s;
      digits_r <= digits_s;
    end
  end

  // Status outputs decoded from the state register only.
  always_comb begin
    ready     = 1'b0;
    done_tick = 1'b0;
    case (state_r)
      IDLE:    ready     = 1'b1;
      OP:      ready     = 1'b0;
      DONE:    done_tick = 1'b1;
      default: ready     = 1'b0;
    endcase
  end

  assign bcd3 = digits_r[3];
  assign bcd2 = digits_r[2];
  assign bcd1 = digits_r[1];
  assign bcd0 = digits_r[0];

endmodule

// File: tb/tb_bin2bcd.sv
// Directed self-checking bench for bin2bcd (BIN_W = 13).
module tb_bin2bcd;

  localparam int BIN_W = 13;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [BIN_W-1:0] bin = '0;
  logic             ready;
  logic             done_tick;
  logic [3:0]       bcd3, bcd2, bcd1, bcd0;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  bin2bcd #(.BIN_W(BIN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bin       (bin),
    .ready     (ready),
    .done_tick (done_tick),
    .bcd3      (bcd3),
    .bcd2      (bcd2),
    .bcd1      (bcd1),
    .bcd0      (bcd0)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used to measure start spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int digits();
    return {16'd0, bcd3, bcd2, bcd1, bcd0};
  endfunction

  // Issue one conversion; mode 1 re-pulses start and changes bin during OP.
  // Returns the cycle index at which start was presented.
  task automatic do_conv(input int val, input int exp, input string tag,
                         input int mode, output int start_cyc);
    int lat;
    int w;
    bit seen;
    w = 0;
    while (!ready && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, "_rdy_pre"}, int'(ready), 1);
    bin = BIN_W'(val);
    start = 1'b1;
    start_cyc = cyc;
    lat = 0;
    seen = 1'b0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        start = 1'b0;
        bin = 13'h1abc;
      end
      if (n == 2) check({tag, "_rdy_busy"}, int'(ready), 0);
      if (mode == 1 && n == 3) begin
        start = 1'b1;
        bin = 13'd99;
      end
      if (mode == 1 && n == 6) start = 1'b0;
      if (done_tick) begin
        seen = 1'b1;
        lat = n;
      end
    end
    check({tag, "_lat"}, lat, 14);
    check({tag, "_dig"}, digits(), exp);
    @(posedge clk); #1;
    check({tag, "_tick_off"}, int'(done_tick), 0);
    check({tag, "_rdy_post"}, int'(ready), 1);
    check({tag, "_hold"}, digits(), exp);
  endtask

  // Watch a quiet window: no done_tick must appear and ready must stay high.
  task automatic idle_watch(input string tag, input int cycles);
    int ticks;
    int busy;
    ticks = 0;
    busy = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk); #1;
      if (done_tick) ticks++;
      if (!ready) busy++;
    end
    check({tag, "_ticks"}, ticks, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int s0, s1, s2;
    int ticks;

    // Reset state, with start held high to show reset dominates.
    reset = 1'b1;
    start = 1'b1;
    bin = 13'd55;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", int'(done_tick), 0);
    check("rst_dig", digits(), 0);
    check("rst_ready", int'(ready), 1);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", int'(ready), 1);
    idle_watch("rst_start_dropped", 20);

    // Basic conversions.
    do_conv(55,   32'h0055, "c55",   0, s0);
    do_conv(8191, 32'h8191, "c8191", 0, s0);
    do_conv(0,    32'h0000, "c0",    0, s0);
    do_conv(1000, 32'h1000, "c1000", 0, s0);

    // Start re-pulsed and bin changed during OP: ignored, not queued.
    do_conv(55, 32'h0055, "dist", 1, s0);
    idle_watch("dist_noq", 20);

    // Reset on the 5th OP cycle aborts the conversion.
    bin = 13'd55;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 2; n <= 5; n++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_tick", int'(done_tick), 0);
    check("abort_dig", digits(), 0);
    check("abort_ready", int'(ready), 1);
    ticks = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (done_tick) ticks++;
    end
    check("abort_noresume", ticks, 0);
    do_conv(42, 32'h0042, "c42", 0, s0);

    // Back-to-back starts on the first ready cycle.
    do_conv(55,   32'h0055, "b2b55",   0, s0);
    do_conv(128,  32'h0128, "b2b128",  0, s1);
    do_conv(4095, 32'h4095, "b2b4095", 0, s2);
    check("b2b_gap1", s1 - s0, 15);
    check("b2b_gap2", s2 - s1, 15);

    // Loop-back through a tens/units to binary recombination over 0..99.
    for (int i = 0; i < 100; i++) begin
      do_conv(i, ((i / 10) << 4) | (i % 10), "loop", 0, s0);
      check("loopback", int'(bcd1) * 10 + int'(bcd0), i);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
